// File: rtl/gpu_pkg.sv
// Shared GPU front-end types: shape codes, splitter segment selects and command layout.
package gpu_pkg;

    localparam int OPDATA_W = 74;
    localparam int LOC_W    = 19;
    localparam int COLOR_W  = 16;
    localparam int SEL_W    = 4;
    localparam int WD_W     = 13;

    typedef enum logic [3:0] {
        LINE     = 4'b0000,
        TRIANGLE = 4'b0001,
        CIRCLE   = 4'b0010
    } shape_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } seq_state_t;

    localparam logic [SEL_W-1:0] LL1 = 4'b0000;
    localparam logic [SEL_W-1:0] TL1 = 4'b0001;
    localparam logic [SEL_W-1:0] TL2 = 4'b0010;
    localparam logic [SEL_W-1:0] TL3 = 4'b0011;
    localparam logic [SEL_W-1:0] CA1 = 4'b0100;

    function automatic logic shape_legal(input logic [3:0] code);
        return (code == LINE) || (code == TRIANGLE) || (code == CIRCLE);
    endfunction

    // Triangle segments are consecutive codes starting at TL1.
    function automatic logic [SEL_W-1:0] seg_code(input shape_t shape, input logic [1:0] cnt);
        case (shape)
            TRIANGLE: return TL1 + {2'b00, cnt};
            CIRCLE:   return CA1;
            default:  return LL1;
        endcase
    endfunction

    function automatic logic seg_last(input shape_t shape, input logic [1:0] cnt);
        return (shape == TRIANGLE) ? (cnt == 2'd2) : 1'b1;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter that saturates at rollover_val; flag is high while the count sits there.
module flex_counter #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable && (count_out != rollover_val)) begin
            count_out <= count_out + 1'b1;
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/shape_sequencer.sv
// Walks a shape command through its splitter segments, starting the matching
// rasterizer for each one and waiting for its done (with an optional watchdog).
module shape_sequencer
    import gpu_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                op_valid,
    input  logic [3:0]          op_shape,
    input  logic [OPDATA_W-1:0] op_data,
    output logic                op_ready,
    output logic [OPDATA_W-1:0] opdata,
    output logic [SEL_W-1:0]    output_sel,
    output logic                line_start,
    output logic                circle_start,
    input  logic                line_done,
    input  logic                circle_done,
    output logic                shape_done,
    output logic                bad_shape,
    output logic                timeout
);

    localparam logic [WD_W-1:0] TO_VAL = WD_W'(TIMEOUT);

    seq_state_t      state, state_n;
    shape_t          shape_q;
    logic [1:0]      seg_cnt;
    logic            load_cmd, advance, set_done, set_bad, set_to;
    logic            wd_clear, wd_en, wd_flag, wd_hit;
    logic [WD_W-1:0] wd_count;
    logic            seg_is_circle, seg_done;

    assign seg_is_circle = (output_sel == CA1);
    assign seg_done      = seg_is_circle ? circle_done : line_done;
    assign wd_hit        = (TIMEOUT != 0) && wd_flag;

    flex_counter #(.NUM_BITS(WD_W)) u_watchdog (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (wd_clear),
        .count_enable (wd_en),
        .rollover_val (TO_VAL),
        .count_out    (wd_count),
        .rollover_flag(wd_flag)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        load_cmd     = 1'b0;
        advance      = 1'b0;
        set_done     = 1'b0;
        set_bad      = 1'b0;
        set_to       = 1'b0;
        wd_clear     = 1'b0;
        wd_en        = 1'b0;
        op_ready     = 1'b0;
        line_start   = 1'b0;
        circle_start = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (shape_legal(op_shape)) begin
                        load_cmd = 1'b1;
                        wd_clear = 1'b1;
                        state_n  = S_ISSUE;
                    end else begin
                        set_bad = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                line_start   = !seg_is_circle;
                circle_start = seg_is_circle;
                wd_en        = 1'b1;
                state_n      = S_WAIT;
            end
            S_WAIT: begin
                wd_en = 1'b1;
                // A done on the same edge as the watchdog hit still counts as success.
                if (seg_done) begin
                    if (seg_last(shape_q, seg_cnt)) begin
                        set_done = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        advance  = 1'b1;
                        wd_clear = 1'b1;
                        state_n  = S_ISSUE;
                    end
                end else if (wd_hit) begin
                    set_to  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            opdata     <= '0;
            output_sel <= LL1;
            shape_q    <= LINE;
            seg_cnt    <= 2'd0;
            shape_done <= 1'b0;
            bad_shape  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            shape_done <= set_done;
            bad_shape  <= set_bad;
            timeout    <= set_to;
            if (load_cmd) begin
                opdata     <= op_data;
                shape_q    <= shape_t'(op_shape);
                seg_cnt    <= 2'd0;
                output_sel <= seg_code(shape_t'(op_shape), 2'd0);
            end else if (advance) begin
                seg_cnt    <= seg_cnt + 2'd1;
                output_sel <= seg_code(shape_q, seg_cnt + 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_shape_sequencer.sv
// Directed bench for shape_sequencer: a command table plus hand-written corner sequences.
module tb_shape_sequencer;
    import gpu_pkg::*;

    logic                tb_clk = 1'b0;
    logic                n_rst;
    logic                op_valid;
    logic [3:0]          op_shape;
    logic [OPDATA_W-1:0] op_data;
    logic                line_done, circle_done;

    logic                op_ready, line_start, circle_start, shape_done, bad_shape, timeout;
    logic [OPDATA_W-1:0] opdata;
    logic [SEL_W-1:0]    output_sel;

    logic                w_op_ready, w_line_start, w_circle_start, w_shape_done, w_bad_shape, w_timeout;
    logic [OPDATA_W-1:0] w_opdata;
    logic [SEL_W-1:0]    w_output_sel;

    int checks = 0;
    int errors = 0;

    always #5 tb_clk = ~tb_clk;

    shape_sequencer dut (
        .clk(tb_clk), .n_rst(n_rst), .op_valid(op_valid), .op_shape(op_shape), .op_data(op_data),
        .op_ready(op_ready), .opdata(opdata), .output_sel(output_sel),
        .line_start(line_start), .circle_start(circle_start),
        .line_done(line_done), .circle_done(circle_done),
        .shape_done(shape_done), .bad_shape(bad_shape), .timeout(timeout)
    );

    shape_sequencer #(.TIMEOUT(16)) dut_wd (
        .clk(tb_clk), .n_rst(n_rst), .op_valid(op_valid), .op_shape(op_shape), .op_data(op_data),
        .op_ready(w_op_ready), .opdata(w_opdata), .output_sel(w_output_sel),
        .line_start(w_line_start), .circle_start(w_circle_start),
        .line_done(line_done), .circle_done(circle_done),
        .shape_done(w_shape_done), .bad_shape(w_bad_shape), .timeout(w_timeout)
    );

    typedef struct {
        logic [3:0]          shape;
        logic [OPDATA_W-1:0] data;
        logic                bad;
        int                  nseg;
        logic [11:0]         sels;   // {seg2, seg1, seg0}
        logic                circ;
        int                  gap;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [OPDATA_W-1:0] act, input logic [OPDATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OPDATA_W-1:0] mk(input logic [15:0] c, input logic [18:0] l1,
                                               input logic [18:0] l2, input logic [18:0] l3, input logic f);
        return {c, l1, l2, l3, f};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        logic [OPDATA_W-1:0] exp_opdata;
        logic [SEL_W-1:0]    exp_sel;
        logic [OPDATA_W-1:0] d2, d3;

        vecs[0] = '{4'b0000, mk(16'hF800, 19'h00010, 19'h04B00, 19'h00000, 1'b0), 1'b0, 1, 12'h000, 1'b0, 20};
        vecs[1] = '{4'b0001, mk(16'h07E0, 19'h00101, 19'h20202, 19'h30303, 1'b1), 1'b0, 3, 12'h321, 1'b0, 5};
        vecs[2] = '{4'b0010, mk(16'h001F, 19'h12345, 19'h00020, 19'h00000, 1'b1), 1'b0, 1, 12'h004, 1'b1, 7};
        vecs[3] = '{4'b0111, mk(16'hAAAA, 19'h55555, 19'h2AAAA, 19'h11111, 1'b1), 1'b1, 0, 12'h000, 1'b0, 0};
        vecs[4] = '{4'b0000, mk(16'h1234, 19'h00001, 19'h00002, 19'h00003, 1'b0), 1'b0, 1, 12'h000, 1'b0, 4};
        d2 = mk(16'hBEEF, 19'h00A00, 19'h00B00, 19'h0, 1'b0);
        d3 = mk(16'hCAFE, 19'h01111, 19'h00040, 19'h0, 1'b1);

        n_rst = 1'b0; op_valid = 1'b0; op_shape = '0; op_data = '0;
        line_done = 1'b0; circle_done = 1'b0;
        #12;
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_opdata", opdata, '0);
        chk("rst_sel", output_sel, LL1);
        chk("rst_pulses", {line_start, circle_start, shape_done, bad_shape, timeout}, '0);
        step();
        n_rst = 1'b1;
        step();
        exp_opdata = '0;

        for (int v = 0; v < 5; v++) begin
            op_shape = vecs[v].shape; op_data = vecs[v].data; op_valid = 1'b1;
            step();
            op_valid = 1'b0;
            if (vecs[v].bad) begin
                chk("bad_pulse", bad_shape, 1'b1);
                chk("bad_no_start", {line_start, circle_start}, '0);
                chk("bad_ready", op_ready, 1'b1);
                chk("bad_opdata", opdata, exp_opdata);
                step();
                chk("bad_clear", bad_shape, 1'b0);
            end else begin
                exp_opdata = vecs[v].data;
                for (int s = 0; s < vecs[v].nseg; s++) begin
                    exp_sel = vecs[v].sels[s*4 +: 4];
                    chk("issue_sel", output_sel, exp_sel);
                    chk("issue_line_start", line_start, !vecs[v].circ);
                    chk("issue_circle_start", circle_start, vecs[v].circ);
                    chk("issue_ready", op_ready, 1'b0);
                    chk("issue_opdata", opdata, exp_opdata);
                    for (int g = 0; g < vecs[v].gap; g++) begin
                        // The rasterizer that does not own this segment reports done mid-wait.
                        if (g == vecs[v].gap / 2) begin
                            line_done   = vecs[v].circ;
                            circle_done = !vecs[v].circ;
                        end else begin
                            line_done = 1'b0; circle_done = 1'b0;
                        end
                        step();
                        chk("wait_no_start", {line_start, circle_start}, '0);
                        chk("wait_sel", output_sel, exp_sel);
                        chk("wait_opdata", opdata, exp_opdata);
                        chk("wait_busy", {op_ready, shape_done}, '0);
                    end
                    line_done   = !vecs[v].circ;
                    circle_done = vecs[v].circ;
                    step();
                    line_done = 1'b0; circle_done = 1'b0;
                    if (s == vecs[v].nseg - 1) begin
                        chk("shape_done", shape_done, 1'b1);
                        chk("done_ready", op_ready, 1'b1);
                        step();
                        chk("shape_done_clear", shape_done, 1'b0);
                    end
                end
            end
        end

        // Done during ISSUE is dropped; op_valid while busy is ignored.
        op_shape = 4'b0000; op_data = d2; op_valid = 1'b1;
        step();
        op_shape = 4'b0001; line_done = 1'b1;
        step();
        line_done = 1'b0;
        chk("issue_done_ignored", {op_ready, shape_done}, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("busy_valid_sel", output_sel, LL1);
            chk("busy_valid_start", {line_start, circle_start}, '0);
            chk("busy_valid_opdata", opdata, d2);
        end
        op_valid = 1'b0;
        line_done = 1'b1;
        step();
        line_done = 1'b0;
        chk("late_done", shape_done, 1'b1);
        // Back-to-back acceptance in the shape_done cycle.
        op_shape = 4'b0010; op_data = d3; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk("b2b_start", {line_start, circle_start}, 2'b01);
        chk("b2b_sel", output_sel, CA1);
        chk("b2b_opdata", opdata, d3);
        step();
        circle_done = 1'b1;
        step();
        circle_done = 1'b0;
        chk("b2b_done", shape_done, 1'b1);
        line_done = 1'b1;
        step();
        line_done = 1'b0;
        chk("idle_done_ignored", {shape_done, op_ready}, 2'b01);
        step();
        chk("idle_done_not_kept", shape_done, 1'b0);

        // Watchdog: TIMEOUT=16 instance aborts 16 cycles after entering WAIT.
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        op_shape = 4'b0000; op_data = d2; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk("wd_issue", w_line_start, 1'b1);
        step();
        for (int i = 1; i < 16; i++) begin
            step();
            chk("wd_early", {w_timeout, w_op_ready}, '0);
        end
        step();
        chk("wd_timeout", w_timeout, 1'b1);
        chk("wd_ready", w_op_ready, 1'b1);
        chk("wd_no_done", w_shape_done, 1'b0);
        chk("wd_default_still_wait", {op_ready, timeout}, '0);
        step();
        chk("wd_timeout_clear", w_timeout, 1'b0);
        line_done = 1'b1;
        step();
        line_done = 1'b0;
        chk("wd_default_done", shape_done, 1'b1);
        chk("wd_idle_done_ignored", w_shape_done, 1'b0);

        // Asynchronous reset during the second triangle segment.
        op_shape = 4'b0001; op_data = d3; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        line_done = 1'b1;
        step();
        line_done = 1'b0;
        chk("rst_mid_seg2", output_sel, TL2);
        step();
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_sel", output_sel, LL1);
        chk("arst_opdata", opdata, '0);
        chk("arst_ready", op_ready, 1'b1);
        chk("arst_pulses", {line_start, circle_start, shape_done, bad_shape, timeout}, '0);
        step();
        n_rst = 1'b1;
        step();
        chk("arst_after", {op_ready, line_start, shape_done}, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shape_sequencer.md
Name: shape_sequencer

Overview:
- Control stage directly upstream of splitter.
- Accepts one shape command (shape code + 74-bit opdata) per valid/ready handshake and holds the opdata stable on splitter.opdata.
- Steps splitter.output_sel through the segment codes for that shape.
- Issues one start pulse per segment to the line or circle rasterizer and waits for its done before advancing.

Parameters:
- TIMEOUT, 4096, max cycles allowed in WAIT per segment before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- op_valid  in  1  command present
- op_shape  in  4  ShapeType: LINE=0000, TRIANGLE=0001, CIRCLE=0010
- op_data  in  74  {color[15:0], loc1[18:0], loc2[18:0], loc3[18:0], fill}
- op_ready  out  1  sequencer can accept a command
- opdata  out  74  latched command to splitter
- output_sel  out  4  segment select to splitter
- line_start  out  1  one-cycle start pulse to line rasterizer
- circle_start  out  1  one-cycle start pulse to circle rasterizer
- line_done  in  1  line rasterizer finished current segment
- circle_done  in  1  circle rasterizer finished
- shape_done  out  1  one-cycle pulse: all segments of the shape finished
- bad_shape  out  1  one-cycle pulse: illegal shape code was consumed
- timeout  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, n_rst.
- Reset values:
  - state IDLE, opdata=0, output_sel=LL1 (0000).
  - line_start, circle_start, shape_done, bad_shape, timeout = 0.
  - op_ready=1 (combinational, high only in IDLE).
- Segment lists:
  - LINE: {LL1=0000}
  - TRIANGLE: {TL1=0001, TL2=0010, TL3=0011}
  - CIRCLE: {CA1=0100}
- Segment counter is 2 bits.
- States:
  - IDLE: op_ready=1. On op_valid at a clock edge, latch op_data into opdata and latch op_shape.
    - Legal shape: load the first segment code into output_sel, clear the counter, go to ISSUE.
    - Illegal shape (any other code): command is consumed, bad_shape pulses in the next cycle, stay in IDLE, opdata and output_sel unchanged.
  - ISSUE: exactly one cycle. line_start=1 for LL1/TL1/TL2/TL3; circle_start=1 for CA1. Go to WAIT, reset the watchdog count.
  - WAIT: output_sel and opdata held stable.
    - Done matching the segment type (line_done for line segments, circle_done for CA1): if more segments remain, increment the counter, load the next code into output_sel, go to ISSUE. Otherwise go to IDLE with shape_done=1 in the first IDLE cycle.
    - The non-matching done is ignored.
    - Watchdog count reaching TIMEOUT (TIMEOUT>0): go to IDLE, timeout=1 in the first IDLE cycle, shape_done stays 0.
- Latency:
  - Command accepted at edge N → ISSUE in cycle N+1 (start pulse and valid output_sel).
  - Final done sampled at edge M → shape_done and op_ready high in cycle M+1.
  - Back-to-back: next command can be accepted at edge M+1.
- Done during ISSUE or IDLE is ignored and is not remembered.
- op_valid outside IDLE is ignored; the upstream holds it until op_ready.
- Reset mid-shape: immediate return to IDLE with all reset values; no done or start emitted.
- Watchdog uses a 13-bit count, saturating, cleared on entry to ISSUE.

Decomposition:
- gpu_pkg:
  - ShapeType enum (LINE/TRIANGLE/CIRCLE).
  - Segment select localparams LL1, TL1, TL2, TL3, CA1.
  - OPDATA_W=74, LOC_W=19, COLOR_W=16.
- Sub-module: flex_counter (existing parameterised counter) for the watchdog; the FSM stays in shape_sequencer.
- The splitter instance lives at the next level up, not inside this block.

Test Plan:
- Line: op_shape=0000, op_data loc1=0x00010, loc2=0x04B00 → ISSUE next cycle with output_sel=0000 and line_start for one cycle; line_done after 20 cycles → shape_done one cycle later, op_ready=1.
- Triangle: shape 0001 with loc1..loc3 distinct → output_sel 0001→0010→0011, three single-cycle line_start pulses each after a line_done; a circle_done injected mid-WAIT is ignored; shape_done pulses once.
- Circle: shape 0010 → output_sel=0100, circle_start once, line_done ignored, circle_done → shape_done; opdata equals the latched command throughout.
- Illegal shape 0111 with op_valid → bad_shape pulses one cycle, no start pulse, op_ready stays 1; then a LINE command is accepted normally.
- Watchdog and reset: TIMEOUT=16, no done after line_start → timeout pulse 16 cycles after WAIT entry, returns to IDLE. Separately, assert n_rst asynchronously during triangle segment 2 → outputs return to reset values immediately.
